// File: rtl/flash_arbiter.sv
// Two-requester arbiter in front of a single flash controller: one transaction in flight,
// strict alternation on ties. Define FLASH_ARB_TIMEOUT_EN to bound the FL_STATUS wait.
module flash_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       CLK_50MHZ,
  input  logic       RST_N,
  input  logic       A_REQ,
  input  logic       A_WR,
  input  logic [7:0] A_ADDR,
  input  logic [7:0] A_WDATA,
  output logic [7:0] A_RDATA,
  output logic       A_DONE,
  output logic       A_ERR,
  input  logic       B_REQ,
  input  logic       B_WR,
  input  logic [7:0] B_ADDR,
  input  logic [7:0] B_WDATA,
  output logic [7:0] B_RDATA,
  output logic       B_DONE,
  output logic       B_ERR,
  output logic [7:0] FL_ADDR,
  output logic [7:0] FL_DOUT,
  input  logic [7:0] FL_DIN,
  output logic       FL_FLOW,
  output logic       FL_TRG,
  input  logic       FL_STATUS,
  output logic       BUSY
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t     state_q, state_d;
  logic       winner_q, winner_d;   // 0 = A, 1 = B
  logic       last_q, last_d;       // last requester served, 0 = A, 1 = B
  logic [7:0] fl_addr_q, fl_addr_d;
  logic [7:0] fl_dout_q, fl_dout_d;
  logic       fl_flow_q, fl_flow_d;
  logic       fl_trg_q, fl_trg_d;
  logic [7:0] a_rdata_q, a_rdata_d;
  logic [7:0] b_rdata_q, b_rdata_d;
  logic       a_done_q, a_done_d;
  logic       b_done_q, b_done_d;
  logic       busy_q, busy_d;
  logic       grant_b;
  logic       finish;
  logic       finish_err;

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

  logic [9:0] cnt_q, cnt_d;
  logic       a_err_q, a_err_d;
  logic       b_err_q, b_err_d;
  logic       timeout_hit;

  // cnt_q counts completed WAIT cycles; the limit is hit on the last allowed one.
  always_comb begin
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;
    if (state_q == ST_ISSUE) begin
      cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      timeout_hit = (cnt_q == TMO_LAST);
      cnt_d       = cnt_q + 10'd1;
    end
    a_err_d = finish_err && !winner_q;
    b_err_d = finish_err && winner_q;
  end

  assign A_ERR = a_err_q;
  assign B_ERR = b_err_q;
`else
  // TIMEOUT_CYCLES has no effect in this build.
  if (TIMEOUT_CYCLES < 0) begin : g_unused_timeout
  end

  assign A_ERR = 1'b0;
  assign B_ERR = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    last_d     = last_q;
    fl_addr_d  = fl_addr_q;
    fl_dout_d  = fl_dout_q;
    fl_flow_d  = fl_flow_q;
    fl_trg_d   = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    a_done_d   = 1'b0;
    b_done_d   = 1'b0;
    grant_b    = 1'b0;
    finish     = 1'b0;
    finish_err = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // On a tie, B wins only if A was served last.
        grant_b = B_REQ && (!A_REQ || !last_q);
        if (A_REQ || B_REQ) begin
          winner_d  = grant_b;
          fl_addr_d = grant_b ? B_ADDR : A_ADDR;
          fl_dout_d = grant_b ? B_WDATA : A_WDATA;
          fl_flow_d = grant_b ? ~B_WR : ~A_WR;
          fl_trg_d  = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (FL_STATUS) begin
          finish = 1'b1;
`ifdef FLASH_ARB_TIMEOUT_EN
        end else if (timeout_hit) begin
          finish     = 1'b1;
          finish_err = 1'b1;
`endif
        end
      end
      ST_DONE: begin
        last_d  = winner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      state_d  = ST_DONE;
      a_done_d = !winner_q;
      b_done_d = winner_q;
      if (!finish_err && fl_flow_q) begin
        if (winner_q) b_rdata_d = FL_DIN;
        else          a_rdata_d = FL_DIN;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      winner_q  <= 1'b0;
      last_q    <= 1'b1;
      fl_addr_q <= '0;
      fl_dout_q <= '0;
      fl_flow_q <= 1'b1;
      fl_trg_q  <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      last_q    <= last_d;
      fl_addr_q <= fl_addr_d;
      fl_dout_q <= fl_dout_d;
      fl_flow_q <= fl_flow_d;
      fl_trg_q  <= fl_trg_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      busy_q    <= busy_d;
`ifdef FLASH_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      a_err_q   <= a_err_d;
      b_err_q   <= b_err_d;
`endif
    end
  end

  assign A_RDATA = a_rdata_q;
  assign A_DONE  = a_done_q;
  assign B_RDATA = b_rdata_q;
  assign B_DONE  = b_done_q;
  assign FL_ADDR = fl_addr_q;
  assign FL_DOUT = fl_dout_q;
  assign FL_FLOW = fl_flow_q;
  assign FL_TRG  = fl_trg_q;
  assign BUSY    = busy_q;

endmodule
